instruction_fetch: RTL

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 93 +++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage: debug-loadable instruction memory, PC register and IF/ID latch under a LOAD/RUN/HALTED FSM.
// One advancing edge from PC to o_instruction; i_step=0 or i_stall=1 (without i_flush) holds every register.
module instruction_fetch #(
  parameter int              NB        = 32,
  parameter int              ADDR_W    = 6,
  parameter logic [NB-1:0]   HALT_WORD = 32'hFFFFFFFF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_step,
  input  logic              i_start,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic              i_pc_src,
  input  logic [NB-1:0]     i_target_pc,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [NB-1:0]     i_wr_data,
  output logic [NB-1:0]     o_pc,
  output logic [NB-1:0]     o_instruction,
  output logic [NB-1:0]     o_pc_plus4,
  output logic              o_valid,
  output logic              o_halt
);

  localparam logic [1:0] ST_LOAD   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic [1:0]    state;
  logic [NB-1:0] mem [2**ADDR_W];
  logic [NB-1:0] fetch_word;
  logic [NB-1:0] pc_plus4;
  logic          advance;

  // Byte PC, word-indexed memory: low two bits dropped, upper bits wrap.
  assign fetch_word = mem[o_pc[ADDR_W+1:2]];
  assign pc_plus4   = o_pc + NB'(4);
  assign advance    = (state == ST_RUN) && i_step && (!i_stall || i_flush);

  // No reset on the array so a loaded program survives a pipeline reset.
  always_ff @(posedge i_clk) begin
    if (state == ST_LOAD && i_wr_en) begin
      mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state         <= ST_LOAD;
      o_pc          <= '0;
      o_instruction <= '0;
      o_pc_plus4    <= '0;
      o_valid       <= 1'b0;
      o_halt        <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (i_start) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (advance) begin
            o_pc_plus4 <= pc_plus4;
            if (i_flush) begin
              o_instruction <= '0;
              o_valid       <= 1'b0;
              o_pc          <= i_pc_src ? i_target_pc : o_pc;
            end else begin
              o_instruction <= fetch_word;
              o_valid       <= 1'b1;
              // A fetched halt freezes PC on itself regardless of any redirect.
              if (fetch_word == HALT_WORD) begin
                o_halt <= 1'b1;
                state  <= ST_HALTED;
              end else begin
                o_pc <= i_pc_src ? i_target_pc : pc_plus4;
              end
            end
          end
        end
        ST_HALTED: begin
          state <= ST_HALTED;
        end
        default: begin
          state <= ST_LOAD;
        end
      endcase
    end
  end

endmodule
